// File: rtl/operand_arbiter.sv
// Round-robin arbiter sharing one registered (a, b) operand path among N_REQ requesters.
// Optional grant/transfer trace printing is enabled by defining OPERAND_ARB_TRACE_EN.
module operand_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ*DATA_W-1:0]    a_i,
  input  logic [N_REQ*DATA_W-1:0]    b_i,
  output logic [N_REQ-1:0]           gnt_o,
  output logic [DATA_W-1:0]          a_o,
  output logic [DATA_W-1:0]          b_o,
  output logic [$clog2(N_REQ)-1:0]   src_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [15:0]                xfer_cnt_o
);

  localparam int unsigned SRC_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = 16;

  logic [SRC_W-1:0]  r_ptr;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [SRC_W-1:0]  r_src;
  logic              r_valid;
  logic [CNT_W-1:0]  r_xfer_cnt;

  logic              w_load_en;
  logic              w_any_req;
  logic              w_grant;
  logic [SRC_W-1:0]  w_winner;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;

  // First requester found scanning upward from ptr, wrapping modulo N_REQ.
  function automatic logic [SRC_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [SRC_W-1:0] ptr);
    logic [SRC_W-1:0] win;
    logic             found;
    int unsigned      idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (32'(ptr) + i) % N_REQ;
      if (!found && req[SRC_W'(idx)]) begin
        win   = SRC_W'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign w_load_en = !r_valid || ready_i;
  assign w_any_req = |req_i;
  assign w_grant   = rst_n && w_load_en && w_any_req;
  assign w_winner  = rr_pick(req_i, r_ptr);
  assign gnt_o     = w_grant ? (N_REQ'(1) << w_winner) : '0;

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (w_winner == SRC_W'(k)) begin
        w_a = a_i[k*DATA_W +: DATA_W];
        w_b = b_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // Output register: replaced on grant, emptied when drained with nothing to load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_src      <= '0;
      r_valid    <= 1'b0;
      r_xfer_cnt <= '0;
    end else begin
      if (w_load_en) begin
        if (w_any_req) begin
          r_a     <= w_a;
          r_b     <= w_b;
          r_src   <= w_winner;
          r_valid <= 1'b1;
          r_ptr   <= (w_winner == SRC_W'(N_REQ - 1)) ? '0 : w_winner + SRC_W'(1);
        end else begin
          r_valid <= 1'b0;
        end
      end
      if (r_valid && ready_i) begin
        r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
      end
    end
  end

`ifdef OPERAND_ARB_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_grant) begin
        $display("arb gnt src: %d, a: %d, b: %d", w_winner, w_a, w_b);
      end
      if (r_valid && ready_i) begin
        $display("arb xfer cnt: %d", r_xfer_cnt + CNT_W'(1));
      end
    end
  end
`else
  // Silent build: no trace output.
`endif

  assign a_o        = r_a;
  assign b_o        = r_b;
  assign src_o      = r_src;
  assign valid_o    = r_valid;
  assign xfer_cnt_o = r_xfer_cnt;

endmodule

// File: doc/operand_arbiter.md
# operand_arbiter

Round-robin arbiter that shares the single registered 8-bit operand-pair path (a, b) among N_REQ requesters. Each requester presents an (a, b) pair with a request. The block grants one requester per cycle, captures the granted pair into an output register, and presents it downstream with a valid/ready handshake. It sits directly in front of the operand capture stage and is the only writer of that stage.

## Interface
- N_REQ, 4, number of requesters; 2..8
- DATA_W, 8, width of each operand
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_i  in  N_REQ  per-requester request; bit k = requester k
- a_i  in  N_REQ*DATA_W  operand a of requester k in bits [k*DATA_W +: DATA_W]
- b_i  in  N_REQ*DATA_W  operand b, same packing as a_i
- gnt_o  out  N_REQ  one-hot grant, combinational, same cycle as transfer
- a_o  out  DATA_W  registered operand a
- b_o  out  DATA_W  registered operand b
- src_o  out  $clog2(N_REQ)  index of requester that supplied a_o/b_o
- valid_o  out  1  output register holds a pair
- ready_i  in  1  downstream accepts the pair when valid_o && ready_i
- xfer_cnt_o  out  16  count of accepted downstream transfers, wraps

## Operation
- load_en = !valid_o || ready_i. The output register loads only when load_en is high.
- Round-robin pointer ptr, range 0..N_REQ-1.
  - Winner = first k with req_i[k] set, searching ptr, ptr+1, ... modulo N_REQ.
- gnt_o[winner] = load_en && |req_i. Otherwise gnt_o is all zeros. gnt_o is never multi-hot.
- On a grant edge:
  - a_o/b_o <= winner's slice.
  - src_o <= winner.
  - valid_o <= 1.
  - ptr <= (winner == N_REQ-1) ? 0 : winner+1.
- On load_en with no requests:
  - valid_o <= 0.
  - a_o, b_o and src_o hold their values.
  - ptr is unchanged.
- While valid_o && !ready_i:
  - a_o, b_o and src_o are held stable.
  - gnt_o = 0.
  - ptr is unchanged.
- Requesters hold req_i and data until they see gnt_o. Dropping req_i before a grant is legal and cancels the request with no transfer.
- xfer_cnt_o increments by 1 on each valid_o && ready_i edge and wraps 0xFFFF -> 0x0000.
- Reset values:
  - valid_o = 0.
  - a_o = b_o = 0.
  - src_o = 0.
  - ptr = 0.
  - xfer_cnt_o = 0.
  - gnt_o is forced to 0 while rst_n is low.
- Reset mid-operation: valid_o falls immediately (asynchronous) and any held pair is discarded. After release, ptr = 0.

## Timing
- Grant-to-output latency: 1 cycle. The pair is granted in cycle n and is visible on a_o/b_o with valid_o = 1 in cycle n+1.
- Throughput: 1 pair per cycle when ready_i is held high and requests are present.
- Simultaneous downstream accept and new grant in the same cycle are allowed. The register is replaced with no bubble.
- Combinational paths: req_i, ready_i and valid_o to gnt_o only. No combinational path from any input to a_o, b_o, valid_o or src_o.
- A single continuous requester receives a grant every cycle. ptr wraps past N_REQ-1 to 0 as described above.

## Configuration
- OPERAND_ARB_TRACE_EN defined:
  - Each grant edge, outside reset, executes $display("arb gnt src: %d, a: %d, b: %d", winner, a, b).
  - Each accepted downstream transfer displays "arb xfer cnt: %d" with the post-increment count.
- Undefined: no simulation output. Functional behaviour is identical in both cases.

## Test plan
- Reset then idle: rst_n low 3 cycles, req_i = 0.
  - Required: valid_o = 0, a_o = b_o = 0, gnt_o = 0, xfer_cnt_o = 0.
- Single requester: req_i = 4'b0100, a = 8'd17, b = 8'd42, ready_i = 1.
  - Required: gnt_o = 4'b0100 in the same cycle.
  - Next cycle: a_o = 17, b_o = 42, src_o = 2, valid_o = 1.
- Round-robin fairness: req_i = 4'b1111 held for 8 cycles, ready_i = 1, from reset.
  - Required: grant order 0,1,2,3,0,1,2,3.
  - xfer_cnt_o = 7 after the 8th grant edge; the 8th pair is still pending downstream.
- Backpressure: valid_o = 1 with pair (5, 9), ready_i = 0 for 4 cycles, req_i = 4'b0011.
  - Required: a_o = 5 and b_o = 9 stable, gnt_o = 0, xfer_cnt_o unchanged.
  - On ready_i = 1: accept and grant occur in the same cycle.
- Wrap and cancel:
  - ptr = 3 with req_i = 4'b1001: grant goes to 3, then to 0.
  - req_i[1] pulsed for one cycle while ready_i = 0: never granted.
  - Counter preset near 0xFFFF rolls over to 0x0000 on the next accepted transfer.
- Mid-operation reset: rst_n pulled low during a stream.
  - Required: valid_o = 0 asynchronously and ptr = 0.
  - First grant after release goes to the lowest requesting index.
